srv_perf_cnt: RTL and testbench

Multi-channel performance counter bank: the parametrised successor of the single cycle counter in the CPU top level. It snoops the core's data-memory write port for a small memory-mapped control window at `BASE_ADDR`. Each of `NUM_CNT` counters can count either clock cycles or cycles where its event input is high. Each channel supports per-channel clear, a sticky overflow flag, selectable wrap or saturate behaviour, and an atomic snapshot of all channels. It sits beside `sr_cpu` in the top level and is clocked by the divided CPU clock.

---
 rtl/srv_perf_cnt.sv | 116 +++++++++++
 tb/tb_srv_perf_cnt.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/srv_perf_cnt.sv
// ============================================================================
// Module   : srv_perf_cnt
// Purpose  : Multi-channel performance counter bank with a memory-mapped
//            control window snooped from the core data-memory write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module srv_perf_cnt #(
   parameter int unsigned NUM_CNT   = 4,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h200,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        wdata_i,
   input  logic [NUM_CNT-1:0] event_i,
   input  logic [4:0]         sel_i,
   output logic [CNT_W-1:0]   live_o,
   output logic [CNT_W-1:0]   snap_o,
   output logic [NUM_CNT-1:0] ovf_o,
   output logic [NUM_CNT-1:0] en_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [NUM_CNT-1:0] en_reg;
   logic [NUM_CNT-1:0] mode_reg;
   logic [NUM_CNT-1:0] clr_pulse;
   logic               snap_pulse;
   logic [NUM_CNT-1:0] wbits;
   logic               hit_enable;
   logic               hit_clear;
   logic               hit_mode;
   logic               hit_snap;
   logic               unused_wdata;
   logic [CNT_W-1:0]   cnt_arr  [NUM_CNT];
   logic [CNT_W-1:0]   snap_arr [NUM_CNT];

   assign wbits        = wdata_i[NUM_CNT-1:0];
   assign unused_wdata = ^wdata_i;

   assign hit_enable = wr_en_i && (addr_i == BASE_ADDR);
   assign hit_clear  = wr_en_i && (addr_i == BASE_ADDR + 32'd1);
   assign hit_mode   = wr_en_i && (addr_i == BASE_ADDR + 32'd2);
   assign hit_snap   = wr_en_i && (addr_i == BASE_ADDR + 32'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg     <= '0;
         mode_reg   <= '0;
         clr_pulse  <= '0;
         snap_pulse <= 1'b0;
      end else begin
         if (hit_enable) en_reg <= wbits;
         if (hit_mode)   mode_reg <= wbits;
         // Clear and snap are one-cycle pulses acted on at the following edge.
         clr_pulse  <= hit_clear ? wbits : '0;
         snap_pulse <= hit_snap;
      end
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] shadow;
      logic             ovf;
      logic             inc;

      assign inc = en_reg[i] && (!mode_reg[i] || event_i[i]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
         end else begin
            // Shadow takes the pre-edge value, so a coincident clear is not seen.
            if (snap_pulse) shadow <= cnt;
            if (clr_pulse[i]) begin
               cnt <= '0;
               ovf <= 1'b0;
            end else if (inc) begin
               if (&cnt) begin
                  ovf <= 1'b1;
                  if (!SATURATE) cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         end
      end

      assign cnt_arr[i]  = cnt;
      assign snap_arr[i] = shadow;
      assign ovf_o[i]    = ovf;
   end

   always_comb begin
      live_o = '0;
      snap_o = '0;
      for (int k = 0; k < NUM_CNT; k++) begin
         if (sel_i == 5'(k)) begin
            live_o = cnt_arr[k];
            snap_o = snap_arr[k];
         end
      end
   end

   assign en_o = en_reg;

endmodule

`default_nettype wire

// File: tb/tb_srv_perf_cnt.sv
// ============================================================================
// Module   : tb_srv_perf_cnt
// Purpose  : Self-checking bench: directed vector table, hand sequences for
//            wrap/saturate/reset, and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_srv_perf_cnt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  ev = '0;
   logic [4:0]  sel = '0;

   logic [31:0] live32, snap32;
   logic [7:0]  live_w, snap_w, live_s, snap_s;
   logic [3:0]  ovf32, en32, ovf_w, en_w, ovf_s, en_s;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   srv_perf_cnt #(.NUM_CNT(4), .CNT_W(32), .BASE_ADDR(32'h200), .SATURATE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .addr_i(addr), .wdata_i(wdata),
      .event_i(ev), .sel_i(sel), .live_o(live32), .snap_o(snap32), .ovf_o(ovf32), .en_o(en32));

   srv_perf_cnt #(.NUM_CNT(4), .CNT_W(8), .BASE_ADDR(32'h200), .SATURATE(1'b0)) dut_w8 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .addr_i(addr), .wdata_i(wdata),
      .event_i(ev), .sel_i(sel), .live_o(live_w), .snap_o(snap_w), .ovf_o(ovf_w), .en_o(en_w));

   srv_perf_cnt #(.NUM_CNT(4), .CNT_W(8), .BASE_ADDR(32'h200), .SATURATE(1'b1)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .addr_i(addr), .wdata_i(wdata),
      .event_i(ev), .sel_i(sel), .live_o(live_s), .snap_o(snap_s), .ovf_o(ovf_s), .en_o(en_s));

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: per-channel event totals since the last clear. The
   // observable value of a W-bit channel follows from the total alone.
   longint     tot  [4] = '{0, 0, 0, 0};
   longint     stot [4] = '{0, 0, 0, 0};
   logic [3:0] m_en = '0, m_mode = '0, m_clr = '0;
   logic       m_snap = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            tot[k]  <= 0;
            stot[k] <= 0;
         end
         m_en <= '0; m_mode <= '0; m_clr <= '0; m_snap <= 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (m_snap) stot[k] <= tot[k];
            if (m_clr[k]) tot[k] <= 0;
            else if (m_en[k] && (!m_mode[k] || ev[k])) tot[k] <= tot[k] + 1;
         end
         m_clr  <= (wr_en && addr == 32'h201) ? wdata[3:0] : 4'h0;
         m_snap <= wr_en && addr == 32'h203;
         if (wr_en && addr == 32'h200) m_en <= wdata[3:0];
         if (wr_en && addr == 32'h202) m_mode <= wdata[3:0];
      end
   end

   function automatic longint view(input longint t, input int w, input bit sat);
      longint lim = longint'(1) << w;
      if (t >= lim) return sat ? lim - 1 : t % lim;
      return t;
   endfunction

   task automatic check_model();
      longint     lt = 0, st = 0;
      logic [3:0] o32, o8;
      if (sel < 5'd4) begin
         lt = tot[sel[1:0]];
         st = stot[sel[1:0]];
      end
      for (int k = 0; k < 4; k++) begin
         o32[k] = tot[k] >= (longint'(1) << 32);
         o8[k]  = tot[k] >= 256;
      end
      chk("model live32", longint'(live32), view(lt, 32, 1'b0));
      chk("model snap32", longint'(snap32), view(st, 32, 1'b0));
      chk("model live_w8", longint'(live_w), view(lt, 8, 1'b0));
      chk("model snap_w8", longint'(snap_w), view(st, 8, 1'b0));
      chk("model live_s8", longint'(live_s), view(lt, 8, 1'b1));
      chk("model snap_s8", longint'(snap_s), view(st, 8, 1'b1));
      chk("model ovf32", longint'(ovf32), longint'(o32));
      chk("model ovf_w8", longint'(ovf_w), longint'(o8));
      chk("model ovf_s8", longint'(ovf_s), longint'(o8));
      chk("model en32", longint'(en32), longint'(m_en));
      chk("model en_s8", longint'(en_s), longint'(m_en));
   endtask

   always @(negedge clk) check_model();

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  ev;
      logic [4:0]  sel;
      int          cycles;
      logic [31:0] exp_live;
      logic [31:0] exp_snap;
      logic [3:0]  exp_en;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] e, input logic [4:0] s, input int c,
                               input logic [31:0] l, input logic [31:0] sn, input logic [3:0] en);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.ev = e; v.sel = s; v.cycles = c;
      v.exp_live = l; v.exp_snap = sn; v.exp_en = en;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(1, 32'h200, 32'h1, 4'h0, 5'd0, 11, 32'd10, 32'd0, 4'h1));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd1, 1,  32'd0,  32'd0, 4'h1));
      tbl.push_back(mk(1, 32'h202, 32'h2, 4'h0, 5'd1, 1,  32'd0,  32'd0, 4'h1));
      tbl.push_back(mk(1, 32'h200, 32'h2, 4'h0, 5'd1, 1,  32'd0,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h2, 5'd1, 1,  32'd1,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd1, 1,  32'd1,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h2, 5'd1, 1,  32'd2,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd1, 1,  32'd2,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd1, 1,  32'd2,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h2, 5'd1, 1,  32'd3,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd1, 1,  32'd3,  32'd0, 4'h2));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'hF, 5'd0, 1,  32'd13, 32'd0, 4'h2));
      tbl.push_back(mk(1, 32'h200, 32'h4, 4'h0, 5'd2, 1,  32'd0,  32'd0, 4'h4));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd2, 50, 32'd50, 32'd0, 4'h4));
      tbl.push_back(mk(1, 32'h203, 32'h0, 4'h0, 5'd2, 1,  32'd51, 32'd0, 4'h4));
      tbl.push_back(mk(1, 32'h201, 32'h4, 4'h0, 5'd2, 1,  32'd52, 32'd51, 4'h4));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd2, 1,  32'd0,  32'd51, 4'h4));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd2, 1,  32'd1,  32'd51, 4'h4));
      tbl.push_back(mk(1, 32'h204, 32'hFFFF_FFFF, 4'h0, 5'd2, 1, 32'd2, 32'd51, 4'h4));
      tbl.push_back(mk(1, 32'h1FF, 32'h0, 4'h0, 5'd2, 1,  32'd3,  32'd51, 4'h4));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd5, 1,  32'd0,  32'd0, 4'h4));
      tbl.push_back(mk(0, 32'h0,   32'h0, 4'h0, 5'd3, 1,  32'd0,  32'd0, 4'h4));

      repeat (3) tick();
      chk("reset live32", longint'(live32), 0);
      chk("reset snap32", longint'(snap32), 0);
      chk("reset ovf32", longint'(ovf32), 0);
      chk("reset en32", longint'(en32), 0);
      rst_n = 1'b1;

      for (int n = 0; n < tbl.size(); n++) begin
         wr_en = tbl[n].wr; addr = tbl[n].addr; wdata = tbl[n].data;
         ev = tbl[n].ev; sel = tbl[n].sel;
         tick();
         wr_en = 1'b0;
         repeat (tbl[n].cycles - 1) tick();
         chk($sformatf("vec%0d live", n), longint'(live32), longint'(tbl[n].exp_live));
         chk($sformatf("vec%0d snap", n), longint'(snap32), longint'(tbl[n].exp_snap));
         chk($sformatf("vec%0d en", n), longint'(en32), longint'(tbl[n].exp_en));
         chk($sformatf("vec%0d ovf", n), longint'(ovf32), 0);
      end

      // Wrap and saturate on the 8-bit instances, channel 0.
      ev = 4'h0; sel = 5'd0;
      wr_en = 1'b1; addr = 32'h201; wdata = 32'hF; tick();
      addr = 32'h202; wdata = 32'h0; tick();
      addr = 32'h200; wdata = 32'h1; tick();
      wr_en = 1'b0;
      chk("enable start live32", longint'(live32), 0);
      repeat (254) tick();
      chk("pre-wrap live_w8", longint'(live_w), 64'hFE);
      chk("pre-wrap ovf_w8", longint'(ovf_w[0]), 0);
      repeat (2) tick();
      chk("wrap live_w8", longint'(live_w), 0);
      chk("wrap ovf_w8", longint'(ovf_w[0]), 1);
      chk("wrap live_s8", longint'(live_s), 64'hFF);
      chk("wrap ovf_s8", longint'(ovf_s[0]), 1);
      chk("wrap live32", longint'(live32), 256);
      wr_en = 1'b1; addr = 32'h201; wdata = 32'h1; tick();
      wr_en = 1'b0; tick();
      chk("clear live_w8", longint'(live_w), 0);
      chk("clear ovf_w8", longint'(ovf_w[0]), 0);
      chk("clear ovf_s8", longint'(ovf_s[0]), 0);
      repeat (300) tick();
      chk("sat live_s8", longint'(live_s), 64'hFF);
      chk("sat ovf_s8", longint'(ovf_s[0]), 1);
      chk("sat live_w8", longint'(live_w), 44);
      chk("sat live32", longint'(live32), 300);

      // Asynchronous reset mid-count, sampled before the next edge.
      #2 rst_n = 1'b0;
      #1;
      chk("async live32", longint'(live32), 0);
      chk("async snap32", longint'(snap32), 0);
      chk("async en32", longint'(en32), 0);
      chk("async live_s8", longint'(live_s), 0);
      chk("async ovf_s8", longint'(ovf_s), 0);
      chk("async ovf_w8", longint'(ovf_w), 0);
      tick();
      rst_n = 1'b1;

      repeat (3000) begin
         wr_en = ($urandom_range(0, 3) == 0);
         addr  = 32'h1FF + 32'($urandom_range(0, 5));
         wdata = $urandom;
         if (addr == 32'h201 && $urandom_range(0, 7) != 0) wdata = 32'h0;
         ev  = 4'($urandom);
         sel = 5'($urandom_range(0, 7));
         tick();
      end
      wr_en = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
